// File: rtl/pwm_ramp_pkg.sv
// pwm_ramp_pkg: shared definitions for the PWM ramp sequencer.
//   - FSM state type and state constants
//   - PWM core load-register base address and address helper
//   - AXI OKAY response code
package pwm_ramp_pkg;

    typedef logic [1:0] ramp_state_t;

    localparam ramp_state_t StIdle  = 2'd0;
    localparam ramp_state_t StScan  = 2'd1;
    localparam ramp_state_t StIssue = 2'd2;
    localparam ramp_state_t StResp  = 2'd3;

    localparam logic [8:0] PWM_LOAD_BASE = 9'h100;
    localparam logic [1:0] OKAY          = 2'b00;

    // Load register of channel ch lives at 0x100 + 4*ch.
    function automatic logic [8:0] load_addr(input logic [5:0] ch);
        return PWM_LOAD_BASE | {1'b0, ch, 2'b00};
    endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// pwm_tick_gen: free-running divider producing a one-cycle tick strobe every
// C_TICK_DIV clock cycles (counter runs 0..C_TICK_DIV-1, tick on the last count).
// Ports:
//   S_AXI_ACLK  clock
//   reset       synchronous active-high reset (counter to 0)
//   tick_o      one-cycle strobe at counter wrap
module pwm_tick_gen #(
    parameter int unsigned C_TICK_DIV = 100000
) (
    input  logic S_AXI_ACLK,
    input  logic reset,
    output logic tick_o
);

    localparam int unsigned CntW = $clog2(C_TICK_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(C_TICK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CntMax);

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/axi_pwm_ramp_sequencer.sv
// axi_pwm_ramp_sequencer: AXI4-Lite write master that slews the duty value of
// each PWM channel toward a software target, one bounded step per update tick,
// writing each new value to the PWM core load register 0x100 + 4*ch.
// Ports:
//   S_AXI_ACLK, reset        clock, synchronous active-high reset
//   tgt_wr_i/chan/value/step local target load strobe (out-of-range chan ignored)
//   busy_o                   scan in progress
//   settled_o                every channel's current value equals its target
//   M_AXI_AW*/W*/B*          AXI4-Lite write channels toward the PWM core
// Optional (macro PWM_RAMP_STATUS_EN):
//   overrun_cnt_o            saturating count of dropped ticks
//   bresp_err_o              sticky OR of non-OKAY write responses
module axi_pwm_ramp_sequencer
    import pwm_ramp_pkg::*;
#(
    parameter int unsigned C_NUM_PWM   = 2,
    parameter int unsigned C_PWM_WIDTH = 24,
    parameter int unsigned C_TICK_DIV  = 100000
) (
    input  logic                   S_AXI_ACLK,
    input  logic                   reset,
    input  logic                   tgt_wr_i,
    input  logic [5:0]             tgt_chan_i,
    input  logic [C_PWM_WIDTH-1:0] tgt_value_i,
    input  logic [C_PWM_WIDTH-1:0] tgt_step_i,
    output logic                   busy_o,
    output logic                   settled_o,
`ifdef PWM_RAMP_STATUS_EN
    output logic [15:0]            overrun_cnt_o,
    output logic [1:0]             bresp_err_o,
`endif
    output logic [8:0]             M_AXI_AWADDR,
    output logic                   M_AXI_AWVALID,
    input  logic                   M_AXI_AWREADY,
    output logic [31:0]            M_AXI_WDATA,
    output logic [3:0]             M_AXI_WSTRB,
    output logic                   M_AXI_WVALID,
    input  logic                   M_AXI_WREADY,
    input  logic [1:0]             M_AXI_BRESP,
    input  logic                   M_AXI_BVALID,
    output logic                   M_AXI_BREADY
);

    localparam int unsigned IdxW = (C_NUM_PWM > 1) ? $clog2(C_NUM_PWM) : 1;

    logic [C_PWM_WIDTH-1:0] cur_q  [C_NUM_PWM];
    logic [C_PWM_WIDTH-1:0] tgt_q  [C_NUM_PWM];
    logic [C_PWM_WIDTH-1:0] step_q [C_NUM_PWM];

    ramp_state_t            state_q, state_d;
    logic [5:0]             ch_q, ch_d;
    logic [C_PWM_WIDTH-1:0] nxt_q, nxt_d, nxt_c;
    logic                   awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic [8:0]             awaddr_q, awaddr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic                   tick_pend_q, tick_pend_d;
    logic                   settled_q, settled_d;
    logic                   tick, cur_we, tgt_hit, last_ch;
    logic [IdxW-1:0]        idx, tidx;
    logic [C_PWM_WIDTH-1:0] cur_c, tgt_c, step_c, dist_c;
    logic                   up_c;

    pwm_tick_gen #(
        .C_TICK_DIV(C_TICK_DIV)
    ) u_tick_gen (
        .S_AXI_ACLK(S_AXI_ACLK),
        .reset     (reset),
        .tick_o    (tick)
    );

    assign idx     = ch_q[IdxW-1:0];
    assign tidx    = tgt_chan_i[IdxW-1:0];
    assign tgt_hit = tgt_wr_i && ({1'b0, tgt_chan_i} < 7'(C_NUM_PWM));
    assign last_ch = (ch_q == 6'(C_NUM_PWM - 1));

    // Slew-limited next value; clamps to target so it never overshoots or wraps.
    always_comb begin
        cur_c  = cur_q[idx];
        tgt_c  = tgt_q[idx];
        step_c = step_q[idx];
        up_c   = (tgt_c > cur_c);
        dist_c = up_c ? (tgt_c - cur_c) : (cur_c - tgt_c);
        if ((step_c == '0) || (dist_c <= step_c)) begin
            nxt_c = tgt_c;
        end else begin
            nxt_c = up_c ? (cur_c + step_c) : (cur_c - step_c);
        end
    end

    // A tick that lands while one is already pending is lost (overrun); a tick
    // coinciding with consumption of the pending one re-arms it.
    always_comb begin
        tick_pend_d = tick_pend_q;
        if ((state_q == StIdle) && tick_pend_q) begin
            tick_pend_d = tick;
        end else if (tick) begin
            tick_pend_d = 1'b1;
        end
    end

    always_comb begin
        settled_d = 1'b1;
        for (int i = 0; i < int'(C_NUM_PWM); i++) begin
            if (cur_q[i] != tgt_q[i]) begin
                settled_d = 1'b0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        nxt_d     = nxt_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        cur_we    = 1'b0;
        case (state_q)
            StIdle: begin
                if (tick_pend_q) begin
                    ch_d    = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (cur_c != tgt_c) begin
                    nxt_d     = nxt_c;
                    awaddr_d  = load_addr(ch_q);
                    wdata_d   = 32'(nxt_c);
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = StIssue;
                end else if (last_ch) begin
                    state_d = StIdle;
                end else begin
                    ch_d = ch_q + 6'd1;
                end
            end
            StIssue: begin
                if (M_AXI_AWREADY) awvalid_d = 1'b0;
                if (M_AXI_WREADY)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = StResp;
                end
            end
            StResp: begin
                if (M_AXI_BVALID) begin
                    cur_we   = 1'b1;
                    bready_d = 1'b0;
                    if (last_ch) begin
                        state_d = StIdle;
                    end else begin
                        ch_d    = ch_q + 6'd1;
                        state_d = StScan;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (reset) begin
            state_q     <= StIdle;
            ch_q        <= '0;
            nxt_q       <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            tick_pend_q <= 1'b0;
            settled_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            nxt_q       <= nxt_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            tick_pend_q <= tick_pend_d;
            settled_q   <= settled_d;
        end
    end

    // cur and tgt are written from independent sources, so a response landing
    // on the channel being retargeted updates both.
    always_ff @(posedge S_AXI_ACLK) begin
        if (reset) begin
            for (int i = 0; i < int'(C_NUM_PWM); i++) begin
                cur_q[i]  <= '0;
                tgt_q[i]  <= '0;
                step_q[i] <= '0;
            end
        end else begin
            if (cur_we) begin
                cur_q[idx] <= nxt_q;
            end
            if (tgt_hit) begin
                tgt_q[tidx]  <= tgt_value_i;
                step_q[tidx] <= tgt_step_i;
            end
        end
    end

`ifdef PWM_RAMP_STATUS_EN
    logic [15:0] overrun_cnt_q;
    logic [1:0]  bresp_err_q;
    logic        overrun;

    assign overrun = tick && tick_pend_q && (state_q != StIdle);

    always_ff @(posedge S_AXI_ACLK) begin
        if (reset) begin
            overrun_cnt_q <= '0;
            bresp_err_q   <= '0;
        end else begin
            if (overrun && (overrun_cnt_q != 16'hFFFF)) begin
                overrun_cnt_q <= overrun_cnt_q + 16'd1;
            end
            if ((state_q == StResp) && M_AXI_BVALID && (M_AXI_BRESP != OKAY)) begin
                bresp_err_q <= bresp_err_q | M_AXI_BRESP;
            end
        end
    end

    assign overrun_cnt_o = overrun_cnt_q;
    assign bresp_err_o   = bresp_err_q;
`else
    logic unused_bresp;
    assign unused_bresp = ^M_AXI_BRESP;
`endif

    assign busy_o        = (state_q != StIdle);
    assign settled_o     = settled_q;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;

endmodule
